// File: rtl/expr_result_unpacker.sv
// Reassembles the 90-bit expression result vector from an MSB-first beat stream and
// splits it into 18 extended fields. Optional beat parity checking: EXPR_UNPACK_PARITY_EN.
module expr_result_unpacker #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic          in_par,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [89:0]   out_raw,
   output logic [143:0]  out_ext,
   output logic          frame_err,
   output logic [15:0]   frame_cnt
);

   localparam int BEATS = (90 + DW - 1) / DW;
   localparam int AW    = BEATS * DW;
   localparam int CW    = $clog2(BEATS);

   typedef enum logic {COLLECT = 1'b0, DROP = 1'b1} state_t;

   state_t             state_r;
   logic [CW-1:0]      beat_cnt_r;
   logic [AW-DW-1:0]   acc_r;
   logic               ready_en_r;
   logic               bad_r;

   logic               accept_s;
   logic               last_beat_s;
   logic               beat_bad_s;
   logic [AW-1:0]      acc_next_s;
   logic [89:0]        frame_s;
   logic               unused_pad_s;

   // Field k has width 4,5,6 repeating; triples 1, 3 and 5 (fields 3-5, 9-11, 15-17) are signed.
   function automatic logic [143:0] ext_fields(input logic [89:0] raw);
      logic [143:0] e;
      int           pos;
      int           w;
      e   = '0;
      pos = 89;
      for (int k = 0; k < 18; k++) begin
         w = 4 + (k % 3);
         for (int b = 0; b < 8; b++) begin
            if (b < w) begin
               e[136 - 8*k + b] = raw[pos - w + 1 + b];
            end else if (((k / 3) % 2) == 1) begin
               e[136 - 8*k + b] = raw[pos];
            end else begin
               e[136 - 8*k + b] = 1'b0;
            end
         end
         pos = pos - w;
      end
      return e;
   endfunction

   function automatic logic par_odd(input logic [DW-1:0] d, input logic p);
      return ^{d, p};
   endfunction

   assign in_ready    = ready_en_r && ((state_r == DROP) || !out_valid || out_ready);
   assign accept_s    = in_valid && in_ready;
   assign last_beat_s = (beat_cnt_r == CW'(BEATS - 1));
   assign acc_next_s  = {acc_r, in_data};
   assign frame_s     = acc_next_s[AW-1 -: 90];
   assign unused_pad_s = ^acc_next_s;

`ifdef EXPR_UNPACK_PARITY_EN
   assign beat_bad_s = par_odd(in_data, in_par);
`else
   logic unused_par_s;
   assign unused_par_s = par_odd(in_data, in_par);
   assign beat_bad_s   = 1'b0;
`endif

   // Beat collection FSM, output holding register and delivered-frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= COLLECT;
         beat_cnt_r <= '0;
         acc_r      <= '0;
         ready_en_r <= 1'b0;
         bad_r      <= 1'b0;
         out_valid  <= 1'b0;
         out_raw    <= '0;
         out_ext    <= '0;
         frame_err  <= 1'b0;
         frame_cnt  <= 16'd0;
      end else begin
         ready_en_r <= 1'b1;
         frame_err  <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (accept_s) begin
            case (state_r)
               COLLECT: begin
                  acc_r <= acc_next_s[AW-DW-1:0];
                  if (last_beat_s) begin
                     beat_cnt_r <= '0;
                     bad_r      <= 1'b0;
                     if (!in_last) begin
                        frame_err <= 1'b1;
                        state_r   <= DROP;
                     end else if (bad_r || beat_bad_s) begin
                        frame_err <= 1'b1;
                     end else begin
                        out_valid <= 1'b1;
                        out_raw   <= frame_s;
                        out_ext   <= ext_fields(frame_s);
                     end
                  end else if (in_last) begin
                     frame_err  <= 1'b1;
                     beat_cnt_r <= '0;
                     bad_r      <= 1'b0;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + CW'(1);
                     bad_r      <= bad_r | beat_bad_s;
                  end
               end
               DROP: begin
                  if (in_last) begin
                     state_r    <= COLLECT;
                     beat_cnt_r <= '0;
                  end
               end
               default: begin
                  state_r    <= COLLECT;
                  beat_cnt_r <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Randomized and directed bench for expr_result_unpacker with a field-arithmetic reference model.
module tb_expr_result_unpacker;

   localparam int DW    = 8;
   localparam int BEATS = (90 + DW - 1) / DW;
   localparam int AW    = BEATS * DW;
   localparam int PADW  = AW - 90;
   localparam logic [91:0] T1W = 92'h2AB_CDEF_0123_4567_89AB_CDEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_par = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [89:0]   out_raw;
   logic [143:0]  out_ext;
   logic          frame_err;
   logic [15:0]   frame_cnt;

   int tests = 0;
   int fails = 0;
   int exp_err = 0;
   int err_seen = 0;
   int good_sent = 0;
   logic [89:0] exp_q[$];

   expr_result_unpacker #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_par(in_par),
      .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw),
      .out_ext(out_ext), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic int fw(input int k);
      return 4 + (k % 3);
   endfunction

   function automatic int foff(input int k);
      return 15 * (k / 3) + ((k % 3 == 0) ? 0 : ((k % 3 == 1) ? 4 : 9));
   endfunction

   function automatic logic [143:0] model_ext(input logic [89:0] y);
      logic [143:0] e;
      logic [89:0]  t;
      int           v;
      int           w;
      e = '0;
      for (int k = 0; k < 18; k++) begin
         w = fw(k);
         t = y >> (90 - foff(k) - w);
         v = int'(t[7:0]) & ((1 << w) - 1);
         if (((k / 3) % 2) == 1 && v >= (1 << (w - 1))) v = v - (1 << w);
         e[143 - 8*k -: 8] = v[7:0];
      end
      return e;
   endfunction

   function automatic logic [89:0] put_field(input logic [89:0] y, input int k, input int val);
      logic [89:0] r;
      r = y;
      for (int b = 0; b < fw(k); b++) r[90 - foff(k) - fw(k) + b] = val[b];
      return r;
   endfunction

   function automatic logic [89:0] rand_y();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[89:0];
   endfunction

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Output-side scoreboard: every handshaked frame must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && frame_err) err_seen++;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_frame", 160'(out_valid), 160'd0);
         end else begin
            check("out_raw", 160'(out_raw), 160'(exp_q[0]));
            check("out_ext", 160'(out_ext), 160'(model_ext(exp_q[0])));
            exp_q.delete(0);
         end
      end
   end

   task automatic send_frame(input logic [89:0] y, input int nb, input int last_at,
                             input int par_beat, input bit zero_pad, input int gap, input bit rnd_rdy);
      logic [AW-1:0] pk;
      bit            par_bad;
      bit            good;
      bit            acc;
      int            err_beat;
      int            to;
      pk = {y, PADW'(0)};
      if (!zero_pad) pk[PADW-1:0] = PADW'($urandom);
      par_bad = 1'b0;
`ifdef EXPR_UNPACK_PARITY_EN
      par_bad = (par_beat >= 0) && (par_beat <= last_at);
`endif
      if (last_at < BEATS - 1)      err_beat = last_at;
      else if (last_at > BEATS - 1) err_beat = BEATS - 1;
      else if (par_bad)             err_beat = last_at;
      else                          err_beat = -1;
      good = (err_beat < 0);
      if (good) begin
         exp_q.push_back(y);
         good_sent++;
      end else begin
         exp_err++;
      end
      for (int i = 0; i < nb; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
         in_data  = (i < BEATS) ? pk[AW-1-i*DW -: DW] : DW'($urandom);
         in_last  = (i == last_at);
         in_par   = (^in_data) ^ (i == par_beat);
         in_valid = 1'b1;
         acc = 1'b0;
         to  = 0;
         while (!acc && to < 200) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_ready;
            @(posedge clk); #1;
            to++;
         end
         if (!acc) begin
            check("accept_timeout", 160'(acc), 160'd1);
            in_valid = 1'b0;
            return;
         end
         check($sformatf("frame_err_b%0d", i), 160'(frame_err), 160'(i == err_beat));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("out_valid_latency", 160'(out_valid), 160'(good));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("queue_empty", 160'(exp_q.size()), 160'd0);
      check("frame_cnt", 160'(frame_cnt), 160'(16'(good_sent)));
      check("err_count", 160'(err_seen), 160'(exp_err));
   endtask

   initial begin
      logic [89:0] y;
      logic [89:0] y1;
      logic [91:0] t1w;
      int          kind;
      int          la;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 160'(in_ready), 160'd0);
      check("rst_out_valid", 160'(out_valid), 160'd0);
      check("rst_out_raw", 160'(out_raw), 160'd0);
      check("rst_out_ext", 160'(out_ext), 160'd0);
      check("rst_frame_err", 160'(frame_err), 160'd0);
      check("rst_frame_cnt", 160'(frame_cnt), 160'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_rst", 160'(in_ready), 160'd1);

      // Known vector, zero pad, back-to-back beats.
      t1w = T1W;
      y   = t1w[89:0];
      send_frame(y, BEATS, BEATS - 1, -1, 1'b1, 0, 1'b0);
      check("t1_raw", 160'(out_raw), 160'(y));
      check("t1_field0", 160'(out_ext[143 -: 8]), 160'(8'h0A));
      @(posedge clk); #1;
      check("t1_frame_cnt", 160'(frame_cnt), 160'd1);
      check("t1_valid_clr", 160'(out_valid), 160'd0);

      // Sign versus zero extension.
      y = put_field(rand_y(), 0, 15);
      y = put_field(y, 3, 8);
      y = put_field(y, 4, 3);
      send_frame(y, BEATS, BEATS - 1, -1, 1'b0, 0, 1'b0);
      check("t2_field0", 160'(out_ext[143 -: 8]), 160'(8'h0F));
      check("t2_field3", 160'(out_ext[119 -: 8]), 160'(8'hF8));
      check("t2_field4", 160'(out_ext[111 -: 8]), 160'(8'h03));

      // Short frame, then a good one; long frame, then a good one.
      send_frame(rand_y(), 6, 5, -1, 1'b0, 1, 1'b0);
      send_frame(rand_y(), BEATS, BEATS - 1, -1, 1'b0, 1, 1'b0);
      send_frame(rand_y(), 14, 13, -1, 1'b0, 1, 1'b0);
      send_frame(rand_y(), BEATS, BEATS - 1, -1, 1'b0, 1, 1'b0);
      drain();

      // Backpressure: frame 1 held, frame 2 beat 0 stalled.
      out_ready = 1'b0;
      y1 = rand_y();
      send_frame(y1, BEATS, BEATS - 1, -1, 1'b0, 0, 1'b0);
      y = rand_y();
      in_data  = y[89 -: DW];
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("t5_in_ready", 160'(in_ready), 160'd0);
         check("t5_raw_stable", 160'(out_raw), 160'(y1));
      end
      out_ready = 1'b1;
      send_frame(y, BEATS, BEATS - 1, -1, 1'b0, 0, 1'b0);
      drain();

      // Bad parity on beat 7 (ignored without the parity option), bad parity in a short frame.
      send_frame(rand_y(), BEATS, BEATS - 1, 7, 1'b0, 0, 1'b0);
      send_frame(rand_y(), 6, 5, 2, 1'b0, 0, 1'b0);
      send_frame(rand_y(), 14, 13, 3, 1'b0, 0, 1'b0);
      send_frame(rand_y(), BEATS, BEATS - 1, -1, 1'b0, 0, 1'b0);
      drain();

      // Random mix of frame kinds with random gaps and consumer stalls.
      for (int n = 0; n < 30; n++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            send_frame(rand_y(), BEATS, BEATS - 1, -1, 1'b0, 2, 1'b1);
         end else if (kind == 6) begin
            la = $urandom_range(0, BEATS - 2);
            send_frame(rand_y(), la + 1, la, -1, 1'b0, 2, 1'b1);
         end else if (kind == 7) begin
            la = $urandom_range(BEATS, BEATS + 3);
            send_frame(rand_y(), la + 1, la, -1, 1'b0, 2, 1'b1);
         end else begin
            send_frame(rand_y(), BEATS, BEATS - 1, $urandom_range(0, BEATS - 1), 1'b0, 2, 1'b1);
         end
      end
      drain();

      // Reset in the middle of a frame.
      y = rand_y();
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = y[89 - i*DW -: DW];
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 160'(in_ready), 160'd0);
      check("mid_rst_out_valid", 160'(out_valid), 160'd0);
      check("mid_rst_out_raw", 160'(out_raw), 160'd0);
      check("mid_rst_out_ext", 160'(out_ext), 160'd0);
      check("mid_rst_frame_err", 160'(frame_err), 160'd0);
      check("mid_rst_frame_cnt", 160'(frame_cnt), 160'd0);
      in_valid = 1'b0;
      exp_q.delete();
      good_sent = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(rand_y(), BEATS, BEATS - 1, -1, 1'b0, 0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
